// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path and its source arbiter.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Counter width able to hold 0..max_val; at least one bit so a zero limit still elaborates.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping past N-1 to 0.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = IW + 1;

    logic [SW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit to ptr is the one kept.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + SW'(i);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte sources with round-robin, packet-locked grants
// and a one-byte holding register so accepted bytes stream back-to-back.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_valid,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BW  = cnt_width(MAX_BURST);
    localparam int unsigned BW1 = BW + 1;
    localparam int unsigned TW  = cnt_width(LOCK_TIMEOUT);

    // Elaboration-time parameter range checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST > 65535) begin : g_bad_max_burst
        $error("uart_tx_arbiter: MAX_BURST must be <= 65535");
    end
    if (LOCK_TIMEOUT > 65535) begin : g_bad_lock_timeout
        $error("uart_tx_arbiter: LOCK_TIMEOUT must be <= 65535");
    end

    arb_state_e           state;
    logic [IDW-1:0]       rr_ptr;
    logic [BW-1:0]        burst_cnt;
    logic [TW-1:0]        idle_cnt;

    logic                 pick_any_c;
    logic [IDW-1:0]       pick_idx_c;
    logic [DATA_BITS-1:0] sel_data_c;
    logic                 sel_valid_c;
    logic                 sel_last_c;
    logic                 ready_c;
    logic                 accept_c;
    logic                 drain_c;
    logic                 burst_hit_c;
    logic                 timeout_hit_c;
    logic                 release_c;
    logic [IDW-1:0]       next_ptr_c;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any_c),
        .idx (pick_idx_c)
    );

    // Mux the granted source's byte, valid and last flag.
    always_comb begin
        sel_data_c  = '0;
        sel_valid_c = req_valid[grant_id];
        sel_last_c  = req_last[grant_id];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_data_c = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Handshake, release conditions and next round-robin pointer.
    always_comb begin
        ready_c       = (state == LOCK) && (!tx_valid || tx_ready);
        accept_c      = ready_c && sel_valid_c;
        drain_c       = tx_valid && tx_ready;
        burst_hit_c   = (MAX_BURST != 0) &&
                        ((BW1'(burst_cnt) + BW1'(1)) == BW1'(MAX_BURST));
        timeout_hit_c = (LOCK_TIMEOUT != 0) && !sel_valid_c &&
                        (idle_cnt == TW'(LOCK_TIMEOUT - 1));
        release_c     = (state == LOCK) &&
                        ((accept_c && (sel_last_c || burst_hit_c)) || timeout_hit_c);
        next_ptr_c    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end

    // Only the grantee may see ready; it is qualified by hold-register space.
    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = ready_c;
    end

    assign busy = (state == LOCK) || tx_valid;

    // Arbitration FSM with grant, round-robin pointer and lock counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any_c) begin
                        state     <= LOCK;
                        grant_id  <= pick_idx_c;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                LOCK: begin
                    if (accept_c) begin
                        if (burst_cnt != '1) begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                        idle_cnt <= '0;
                    end else if (!sel_valid_c && idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                    if (release_c) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: load wins over drain so a same-cycle swap keeps tx_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (accept_c) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_data_c;
        end else if (drain_c) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a uart_tx ready model and a scoreboard monitor.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DB = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]    rv  [2] = '{default: '0};
    logic [NR*DB-1:0] rd  [2] = '{default: '0};
    logic [NR-1:0]    rl  [2] = '{default: '0};
    logic [NR-1:0]    rr  [2];
    logic             txv [2];
    logic [DB-1:0]    txd [2];
    logic             txr [2] = '{default: 1'b1};
    logic [1:0]       gid [2];
    logic             bsy [2];

    logic [8:0]       sq [2*NR][$];
    logic [7:0]       exp_q [2][$];
    logic [2*NR-1:0]  src_fire = '0;
    logic             tx_fire [2] = '{default: 1'b0};
    int               tx_cnt [2] = '{default: 0};
    logic             stall [2] = '{default: 1'b0};
    int               n_cmp = 0;
    int               n_bad = 0;

    // Instance a: burst cap 16, short lock timeout of 8 idle cycles.
    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .MAX_BURST(16), .LOCK_TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]),
        .req_ready(rr[0]), .tx_valid(txv[0]), .tx_data(txd[0]), .tx_ready(txr[0]),
        .grant_id(gid[0]), .busy(bsy[0])
    );

    // Instance b: burst cap of 2 bytes per grant.
    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .MAX_BURST(2), .LOCK_TIMEOUT(1024)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]),
        .req_ready(rr[1]), .tx_valid(txv[1]), .tx_data(txd[1]), .tx_ready(txr[1]),
        .grant_id(gid[1]), .busy(bsy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic push(input int d, input int i, input logic [7:0] b, input logic last);
        sq[d*NR+i].push_back({last, b});
    endtask

    task automatic expect_tx(input int d, input logic [7:0] b);
        exp_q[d].push_back(b);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit drained(input int d);
        bit ok;
        ok = (exp_q[d].size() == 0) && !txv[d] && txr[d];
        for (int i = 0; i < NR; i++) begin
            if (sq[d*NR+i].size() != 0) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic wait_drain(input int d, input string name);
        int t;
        t = 0;
        while (!drained(d) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: drain timeout, %0d bytes outstanding, want 0", name, exp_q[d].size());
        end
        step(2);
    endtask

    // Monitor: on every transmitter handshake pop the scoreboard and compare.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            tx_fire[d] = txv[d] & txr[d];
            if (txv[d] && txr[d]) begin
                if (exp_q[d].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx dut%0d: got %0h want none", d, txd[d]);
                end else begin
                    check($sformatf("tx_byte dut%0d", d), 32'(txd[d]), 32'(exp_q[d].pop_front()));
                end
            end
            for (int i = 0; i < NR; i++) begin
                src_fire[d*NR+i] = rv[d][i] & rr[d][i];
            end
        end
    end

    // Drivers: uart_tx ready model and source queues, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (tx_fire[d]) tx_cnt[d] = 10;
            else if (tx_cnt[d] > 0) tx_cnt[d]--;
            txr[d] = (tx_cnt[d] == 0) && !stall[d];
            for (int i = 0; i < NR; i++) begin
                if (src_fire[d*NR+i] && sq[d*NR+i].size() > 0) void'(sq[d*NR+i].pop_front());
                if (sq[d*NR+i].size() > 0) begin
                    rv[d][i]           = 1'b1;
                    rd[d][i*DB +: DB]  = sq[d*NR+i][0][7:0];
                    rl[d][i]           = sq[d*NR+i][0][8];
                end else begin
                    rv[d][i]           = 1'b0;
                    rd[d][i*DB +: DB]  = '0;
                    rl[d][i]           = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t2 [8];
        t2 = '{8'h42, 8'h43, 8'h40, 8'h41, 8'h52, 8'h53, 8'h50, 8'h51};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Reset state
        check("rst_tx_valid", 32'(txv[0]), 32'd0);
        check("rst_tx_data",  32'(txd[0]), 32'd0);
        check("rst_req_ready", 32'(rr[0]), 32'd0);
        check("rst_busy",     32'(bsy[0]), 32'd0);
        check("rst_grant_id", 32'(gid[0]), 32'd0);
        check("rst_b_tx_valid", 32'(txv[1]), 32'd0);

        // 1: single byte from src1, ready at cycle 1, tx_valid at cycle 2
        push(0, 1, 8'hA5, 1'b1);
        expect_tx(0, 8'hA5);
        step(2);
        check("t1_req_ready", 32'(rr[0]), 32'b0010);
        check("t1_grant_id",  32'(gid[0]), 32'd1);
        check("t1_tx_valid_early", 32'(txv[0]), 32'd0);
        step(1);
        check("t1_tx_valid", 32'(txv[0]), 32'd1);
        check("t1_tx_data",  32'(txd[0]), 32'hA5);
        check("t1_ready_after_release", 32'(rr[0]), 32'd0);
        check("t1_busy", 32'(bsy[0]), 32'd1);
        wait_drain(0, "t1_drain");
        check("t1_idle_busy", 32'(bsy[0]), 32'd0);

        // 2: round robin, rr_ptr starts at 2 after the src1 grant
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) begin
                push(0, i, 8'(8'h40 + 16 * k + i), 1'b1);
            end
        end
        for (int j = 0; j < 8; j++) expect_tx(0, t2[j]);
        wait_drain(0, "t2_drain");

        // 3: packet lock on src0 while src2 waits
        push(0, 0, 8'h11, 1'b0);
        push(0, 0, 8'h22, 1'b0);
        push(0, 0, 8'h33, 1'b1);
        expect_tx(0, 8'h11); expect_tx(0, 8'h22); expect_tx(0, 8'h33); expect_tx(0, 8'h77);
        step(2);
        check("t3_grant_id", 32'(gid[0]), 32'd0);
        step(1);
        push(0, 2, 8'h77, 1'b1);
        wait_drain(0, "t3_drain");

        // 3b: burst cap of 2 forces release mid-packet
        push(1, 0, 8'h11, 1'b0);
        push(1, 0, 8'h22, 1'b0);
        push(1, 0, 8'h33, 1'b1);
        expect_tx(1, 8'h11); expect_tx(1, 8'h22); expect_tx(1, 8'h7C); expect_tx(1, 8'h33);
        step(3);
        push(1, 2, 8'h7C, 1'b1);
        wait_drain(1, "t3b_drain");

        // 4: backpressure for 50 cycles with the hold register full
        stall[0] = 1'b1;
        push(0, 3, 8'h91, 1'b0);
        push(0, 3, 8'h92, 1'b0);
        push(0, 3, 8'h93, 1'b1);
        expect_tx(0, 8'h91); expect_tx(0, 8'h92); expect_tx(0, 8'h93);
        step(4);
        for (int j = 0; j < 5; j++) begin
            step(10);
            check("t4_tx_data_stable", 32'(txd[0]), 32'h91);
            check("t4_tx_valid", 32'(txv[0]), 32'd1);
            check("t4_req_ready", 32'(rr[0]), 32'd0);
        end
        stall[0] = 1'b0;
        wait_drain(0, "t4_drain");

        // 5: lock timeout after 8 idle cycles, src3 waiting
        push(0, 1, 8'h5A, 1'b0);
        push(0, 3, 8'h3C, 1'b1);
        expect_tx(0, 8'h5A); expect_tx(0, 8'h3C);
        step(10);
        check("t5_still_locked", 32'(bsy[0]), 32'd1);
        check("t5_grant_src1",   32'(gid[0]), 32'd1);
        step(1);
        check("t5_released", 32'(bsy[0]), 32'd0);
        step(1);
        check("t5_grant_src3", 32'(gid[0]), 32'd3);
        check("t5_busy",       32'(bsy[0]), 32'd1);
        wait_drain(0, "t5_drain");

        // 6: reset mid-burst with the hold register full, then a tie at rr_ptr 0
        stall[0] = 1'b1;
        push(0, 2, 8'hE1, 1'b0);
        push(0, 2, 8'hE2, 1'b0);
        push(0, 2, 8'hE3, 1'b1);
        step(6);
        check("t6_hold_full", 32'(txv[0]), 32'd1);
        check("t6_hold_data", 32'(txd[0]), 32'hE1);
        push(0, 0, 8'h0F, 1'b1);
        expect_tx(0, 8'h0F); expect_tx(0, 8'hE2); expect_tx(0, 8'hE3);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_tx_valid", 32'(txv[0]), 32'd0);
        check("t6_async_req_ready", 32'(rr[0]), 32'd0);
        check("t6_async_busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        stall[0] = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_tie_grant", 32'(gid[0]), 32'd0);
        check("t6_tie_ready", 32'(rr[0]), 32'b0001);
        wait_drain(0, "t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
